// File: rtl/life_grid_engine_if.sv
// Register-controller-facing bundle for the Game-of-Life engine: row load and
// readback, run control and status. The controller side uses the master
// modport and the engine uses the slave modport.
interface life_grid_engine_if #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int GEN_W  = 16
);
    localparam int AW = $clog2(GRID_H);
    localparam int CW = $clog2(GRID_W * GRID_H + 1);

    logic              row_wr_en;
    logic [AW-1:0]     row_wr_addr;
    logic [GRID_W-1:0] row_wr_data;
    logic [AW-1:0]     row_rd_addr;
    logic [GRID_W-1:0] row_rd_data;
    logic              start;
    logic [GEN_W-1:0]  gen_count;
    logic              wrap;
    logic              busy;
    logic              done;
    logic [GEN_W-1:0]  gen_done;
    logic [CW-1:0]     alive_count;

    modport master (
        output row_wr_en, row_wr_addr, row_wr_data, row_rd_addr,
               start, gen_count, wrap,
        input  row_rd_data, busy, done, gen_done, alive_count
    );

    modport slave (
        input  row_wr_en, row_wr_addr, row_wr_data, row_rd_addr,
               start, gen_count, wrap,
        output row_rd_data, busy, done, gen_done, alive_count
    );
endinterface

// File: rtl/life_grid_engine.sv
// Game-of-Life compute core. The committed grid lives in flops; a run walks
// the rows one per cycle into a next-generation buffer (COMPUTE), then swaps
// the buffer in as a whole (COMMIT). Readback, population and generation
// counter are all registered.
module life_grid_engine #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int GEN_W  = 16
) (
    input  logic ACLK,
    input  logic ARESET,
    life_grid_engine_if.slave bus
);
    localparam int AW = $clog2(GRID_H);
    localparam int CW = $clog2(GRID_W * GRID_H + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    // Number of live cells in one row.
    function automatic logic [CW-1:0] row_pop(input logic [GRID_W-1:0] row);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int c = 0; c < GRID_W; c++) begin
            cnt = cnt + CW'(row[c]);
        end
        return cnt;
    endfunction

    // Next state of row 'mid' given its neighbours above/below. The rows are
    // extended by one column each side: bit 0 is column -1, bit GRID_W+1 is
    // column GRID_W; those are the wrapped columns or dead.
    function automatic logic [GRID_W-1:0] life_row(
        input logic [GRID_W-1:0] up,
        input logic [GRID_W-1:0] mid,
        input logic [GRID_W-1:0] dn,
        input logic              wr
    );
        logic [GRID_W+1:0] eu;
        logic [GRID_W+1:0] em;
        logic [GRID_W+1:0] ed;
        logic [GRID_W-1:0] res;
        logic [3:0]        n;
        eu  = {wr & up[0],  up,  wr & up[GRID_W-1]};
        em  = {wr & mid[0], mid, wr & mid[GRID_W-1]};
        ed  = {wr & dn[0],  dn,  wr & dn[GRID_W-1]};
        res = '0;
        for (int c = 0; c < GRID_W; c++) begin
            n = 4'(eu[c]) + 4'(eu[c+1]) + 4'(eu[c+2])
              + 4'(em[c])               + 4'(em[c+2])
              + 4'(ed[c]) + 4'(ed[c+1]) + 4'(ed[c+2]);
            res[c] = (n == 4'd3) | (mid[c] & (n == 4'd2));
        end
        return res;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [GRID_W-1:0] grid_r     [GRID_H];
    logic [GRID_W-1:0] next_r     [GRID_H];
    logic [GRID_W-1:0] grid_nxt_s [GRID_H];
    logic [AW-1:0]     row_idx_r, row_idx_nxt_s;
    logic [GEN_W-1:0]  gen_target_r;
    logic [GEN_W-1:0]  gen_done_r, gen_done_nxt_s;
    logic              wrap_r;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;
    logic              latch_s;
    logic              next_wr_s;
    logic [CW-1:0]     alive_r, alive_nxt_s;
    logic [GRID_W-1:0] rd_data_r;
    logic [GRID_W-1:0] up_s, dn_s, row_new_s;
    logic              last_row_s;
    logic              rd_ok_s, wr_ok_s;

    assign last_row_s = (row_idx_r == AW'(GRID_H - 1));
    assign rd_ok_s    = (int'(bus.row_rd_addr) < GRID_H);
    assign wr_ok_s    = (int'(bus.row_wr_addr) < GRID_H);

    // Neighbour rows of the row being computed, with vertical wrap or dead border.
    always_comb begin
        up_s = '0;
        dn_s = '0;
        if (row_idx_r == AW'(0)) begin
            up_s = wrap_r ? grid_r[GRID_H-1] : '0;
        end else begin
            up_s = grid_r[row_idx_r - AW'(1)];
        end
        if (last_row_s) begin
            dn_s = wrap_r ? grid_r[0] : '0;
        end else begin
            dn_s = grid_r[row_idx_r + AW'(1)];
        end
        row_new_s = life_row(up_s, grid_r[row_idx_r], dn_s, wrap_r);
    end

    // Next-state, grid-update and status decode for the run controller.
    always_comb begin
        state_nxt_s    = state_r;
        row_idx_nxt_s  = row_idx_r;
        gen_done_nxt_s = gen_done_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        latch_s        = 1'b0;
        next_wr_s      = 1'b0;
        grid_nxt_s     = grid_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.row_wr_en && wr_ok_s) begin
                    grid_nxt_s[bus.row_wr_addr] = bus.row_wr_data;
                end else begin
                    grid_nxt_s = grid_r;
                end
                if (bus.start && (bus.gen_count != GEN_W'(0))) begin
                    latch_s        = 1'b1;
                    gen_done_nxt_s = '0;
                    row_idx_nxt_s  = '0;
                    busy_nxt_s     = 1'b1;
                    state_nxt_s    = ST_COMPUTE;
                end else if (bus.start) begin
                    gen_done_nxt_s = '0;
                    done_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                next_wr_s = 1'b1;
                if (last_row_s) begin
                    row_idx_nxt_s = '0;
                    state_nxt_s   = ST_COMMIT;
                end else begin
                    row_idx_nxt_s = row_idx_r + AW'(1);
                end
            end
            ST_COMMIT: begin
                grid_nxt_s     = next_r;
                gen_done_nxt_s = gen_done_r + GEN_W'(1);
                row_idx_nxt_s  = '0;
                if (gen_done_nxt_s == gen_target_r) begin
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_COMPUTE;
                end
            end
            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Population of the grid as it will stand after this edge.
    always_comb begin
        alive_nxt_s = '0;
        for (int r = 0; r < GRID_H; r++) begin
            alive_nxt_s = alive_nxt_s + row_pop(grid_nxt_s[r]);
        end
    end

    // State, grid, buffer and status registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r      <= ST_IDLE;
            row_idx_r    <= '0;
            gen_target_r <= '0;
            gen_done_r   <= '0;
            wrap_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            alive_r      <= '0;
            rd_data_r    <= '0;
            for (int r = 0; r < GRID_H; r++) begin
                grid_r[r] <= '0;
                next_r[r] <= '0;
            end
        end else begin
            state_r    <= state_nxt_s;
            row_idx_r  <= row_idx_nxt_s;
            gen_done_r <= gen_done_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            alive_r    <= alive_nxt_s;
            rd_data_r  <= rd_ok_s ? grid_r[bus.row_rd_addr] : '0;
            grid_r     <= grid_nxt_s;
            if (latch_s) begin
                gen_target_r <= bus.gen_count;
                wrap_r       <= bus.wrap;
            end
            if (next_wr_s) begin
                next_r[row_idx_r] <= row_new_s;
            end
        end
    end

    assign bus.row_rd_data = rd_data_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.gen_done    = gen_done_r;
    assign bus.alive_count = alive_r;
endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: blinker, block, glider on torus and
// against a dead corner, zero-length run, busy-time interference, mid-run reset.
module tb_life_grid_engine;
    logic tb_ACLK;
    logic ARESET;
    int   n_total;
    int   n_bad;
    logic [7:0] exp_g [0:7];

    life_grid_engine_if #(.GRID_W(8), .GRID_H(8), .GEN_W(16)) bus_if ();

    life_grid_engine #(.GRID_W(8), .GRID_H(8), .GEN_W(16)) dut (
        .ACLK   (tb_ACLK),
        .ARESET (ARESET),
        .bus    (bus_if)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
    endtask

    task automatic write_row(input int a, input logic [7:0] d);
        bus_if.row_wr_en   = 1'b1;
        bus_if.row_wr_addr = 3'(a);
        bus_if.row_wr_data = d;
        tick();
        bus_if.row_wr_en   = 1'b0;
    endtask

    task automatic read_row(input int a, output logic [7:0] d);
        bus_if.row_rd_addr = 3'(a);
        tick();
        d = bus_if.row_rd_data;
    endtask

    task automatic check_grid(input string tag);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            read_row(i, d);
            chk($sformatf("%s_row%0d", tag, i), 32'(d), 32'(exp_g[i]));
        end
    endtask

    // Starts a run and counts busy cycles; with interfere set, pokes a row
    // write and a second start partway through the run.
    task automatic run(input int n, input logic w, input logic interfere,
                       input int exp_cycles, input string tag);
        int cnt;
        bus_if.start     = 1'b1;
        bus_if.gen_count = 16'(n);
        bus_if.wrap      = w;
        tick();
        bus_if.start     = 1'b0;
        cnt = 0;
        while (bus_if.busy === 1'b1 && cnt < 2000) begin
            if (interfere && cnt == 3) begin
                bus_if.row_wr_en   = 1'b1;
                bus_if.row_wr_addr = 3'd5;
                bus_if.row_wr_data = 8'hFF;
                bus_if.start       = 1'b1;
                bus_if.gen_count   = 16'd1;
                bus_if.wrap        = ~w;
            end else begin
                bus_if.row_wr_en = 1'b0;
                bus_if.start     = 1'b0;
            end
            cnt++;
            tick();
        end
        bus_if.row_wr_en = 1'b0;
        bus_if.start     = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(cnt), 32'(exp_cycles));
        chk({tag, "_done"}, 32'(bus_if.done), 32'd1);
        tick();
        chk({tag, "_done_pulse"}, 32'(bus_if.done), 32'd0);
    endtask

    task automatic set_exp(input logic [63:0] v);
        for (int i = 0; i < 8; i++) exp_g[i] = v[i*8 +: 8];
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        ARESET  = 1'b0;
        bus_if.row_wr_en   = 1'b0;
        bus_if.row_wr_addr = 3'd0;
        bus_if.row_wr_data = 8'h00;
        bus_if.row_rd_addr = 3'd0;
        bus_if.start       = 1'b0;
        bus_if.gen_count   = 16'd0;
        bus_if.wrap        = 1'b0;
        tick();
        do_reset();
        chk("rst_busy",  32'(bus_if.busy),        32'd0);
        chk("rst_done",  32'(bus_if.done),        32'd0);
        chk("rst_gen",   32'(bus_if.gen_done),    32'd0);
        chk("rst_alive", 32'(bus_if.alive_count), 32'd0);

        // Blinker: horizontal in row 3 (cols 2..4) flips to vertical at col 3.
        write_row(3, 8'h1C);
        chk("blk_alive_wr", 32'(bus_if.alive_count), 32'd3);
        run(1, 1'b0, 1'b0, 9, "blink1");
        set_exp(64'h0000_0008_0808_0000);
        check_grid("blink1");
        chk("blink1_alive", 32'(bus_if.alive_count), 32'd3);
        chk("blink1_gen",   32'(bus_if.gen_done),    32'd1);
        run(2, 1'b0, 1'b0, 18, "blink2");
        check_grid("blink2");
        chk("blink2_gen", 32'(bus_if.gen_done), 32'd2);

        // Zero-length run: done next cycle, never busy, gen_done cleared.
        bus_if.start     = 1'b1;
        bus_if.gen_count = 16'd0;
        tick();
        bus_if.start     = 1'b0;
        chk("zero_busy", 32'(bus_if.busy),     32'd0);
        chk("zero_done", 32'(bus_if.done),     32'd1);
        chk("zero_gen",  32'(bus_if.gen_done), 32'd0);
        tick();
        chk("zero_done_pulse", 32'(bus_if.done), 32'd0);
        chk("zero_busy2",      32'(bus_if.busy), 32'd0);
        check_grid("zero");

        // Block still life in the top-left corner.
        do_reset();
        write_row(0, 8'h03);
        write_row(1, 8'h03);
        run(5, 1'b0, 1'b0, 45, "block");
        set_exp(64'h0000_0000_0000_0303);
        check_grid("block");
        chk("block_alive", 32'(bus_if.alive_count), 32'd4);

        // Row write and second start while busy are both ignored.
        run(2, 1'b0, 1'b1, 18, "intf");
        check_grid("intf");
        chk("intf_gen",   32'(bus_if.gen_done),    32'd2);
        chk("intf_alive", 32'(bus_if.alive_count), 32'd4);

        // Glider on torus: 32 generations = full lap back to the start.
        do_reset();
        write_row(0, 8'h02);
        write_row(1, 8'h04);
        write_row(2, 8'h07);
        run(32, 1'b1, 1'b0, 288, "glide32");
        set_exp(64'h0000_0000_0007_0402);
        check_grid("glide32");
        chk("glide32_alive", 32'(bus_if.alive_count), 32'd5);
        chk("glide32_gen",   32'(bus_if.gen_done),    32'd32);

        // Glider at bottom-right edge, dead border: crashes into a corner block.
        do_reset();
        write_row(5, 8'h40);
        write_row(6, 8'h80);
        write_row(7, 8'hE0);
        run(20, 1'b0, 1'b0, 180, "edge0");
        set_exp(64'hC0C0_0000_0000_0000);
        check_grid("edge0");
        chk("edge0_alive", 32'(bus_if.alive_count), 32'd4);

        // Same start, torus: glider moves +5 rows, +5 cols.
        do_reset();
        write_row(5, 8'h40);
        write_row(6, 8'h80);
        write_row(7, 8'hE0);
        run(20, 1'b1, 1'b0, 180, "edge1");
        set_exp(64'h0000_001C_1008_0000);
        check_grid("edge1");
        chk("edge1_alive", 32'(bus_if.alive_count), 32'd5);

        // Reset on the 4th COMPUTE cycle abandons the run.
        bus_if.start     = 1'b1;
        bus_if.gen_count = 16'd3;
        bus_if.wrap      = 1'b1;
        tick();
        bus_if.start     = 1'b0;
        chk("mid_busy_rise", 32'(bus_if.busy), 32'd1);
        tick();
        tick();
        tick();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        chk("mid_busy",  32'(bus_if.busy),        32'd0);
        chk("mid_done",  32'(bus_if.done),        32'd0);
        chk("mid_gen",   32'(bus_if.gen_done),    32'd0);
        chk("mid_alive", 32'(bus_if.alive_count), 32'd0);
        set_exp(64'h0);
        check_grid("mid");
        tick();
        chk("mid_busy_after", 32'(bus_if.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
